aliens_rom_bus_responder: RTL and testbench
===========================================

// Module: aliens_rom_bus_responder
// PURPOSE
// Responder side of the main-CPU address decode: consumes active-low chip selects for the
// fixed and banked program-ROM windows, holds the bank register, and turns CPU ROM reads
// into SDRAM read requests. Stalls the CPU cycle enable until data returns.
// Sits between the CPU clock-enable divider / address PAL and the SDRAM ROM port.
// PARAMETERS
// SDRAM_AW     22        SDRAM ROM byte-address width
// BANK_W       5         bank register width (banked window = 8 KB pages)
// FIXED_BASE   22'h00000 SDRAM byte offset of fixed 32 KB window (CPU 0x8000-0xFFFF)
// BANKED_BASE  22'h08000 SDRAM byte offset of banked page 0 (CPU 0x6000-0x7FFF)
// TIMEOUT      255       clocks in WAIT without rom_ack before abort; 0 disables
// PORTS
// clk          in   1        system clock
// rst_n        in   1        async active-low reset
// cpu_cen_req  in   1        raw one-clock CPU enable pulse from divider
// cpu_cen      out  1        gated CPU enable (stalled on ROM miss)
// cpu_addr     in   16       CPU address
// cpu_rnw      in   1        1 = read
// cpu_dout     in   8        CPU write data
// cs_rom_n     in   1        fixed-ROM select, active low
// cs_bank_n    in   1        banked-ROM select, active low
// cs_bankreg_n in   1        bank-register select, active low
// rom_req      out  1        SDRAM read request, level
// rom_addr     out  SDRAM_AW SDRAM byte address, stable while rom_req=1
// rom_ack      in   1        one-clock data-valid pulse from SDRAM
// rom_data     in   8        SDRAM read data, valid with rom_ack
// rd_data      out  8        data to CPU read mux (cache entry)
// bank         out  BANK_W   current bank register
// bus_err      out  1        sticky: a request timed out
// BEHAVIOUR
// - Reset: cpu_cen=0, rom_req=0, rom_addr=0, rd_data=8'hFF, bank=0, bus_err=0, cache
//   invalid, state IDLE. Async assertion drops rom_req immediately, mid-request included.
// - Address map: fixed -> FIXED_BASE + cpu_addr[14:0]; banked -> BANKED_BASE +
//   {bank, cpu_addr[12:0]}; sum truncated to SDRAM_AW. cs_rom_n wins if both low.
// - Single-entry cache: tag = mapped SDRAM address, data = rd_data, valid bit.
// - States IDLE, REQ, WAIT, HOLD.
//   IDLE: cpu_cen = cpu_cen_req, except ROM read (cs low, rnw=1) on a cpu_cen_req cycle
//     with cache miss: cpu_cen=0, latch rom_addr, go REQ. Hit: pass enable, zero stall.
//   REQ: rom_req=1 next clock; go WAIT.
//   WAIT: hold rom_req/rom_addr. On rom_ack: rd_data<=rom_data, tag<=rom_addr, valid<=1,
//     rom_req<=0, go HOLD. After TIMEOUT clocks: rd_data<=8'hFF, bus_err<=1, valid<=0,
//     rom_req<=0, go HOLD.
//   HOLD: cpu_cen=0 until next cpu_cen_req; then cpu_cen=1 for that clock, go IDLE
//     (CPU re-presents the same address, now hits).
// - Miss latency: stall = ack latency + 2 clocks, rounded up to next cpu_cen_req.
// - Bank write: cs_bankreg_n=0, rnw=0, cpu_cen_req=1 in IDLE -> bank<=cpu_dout[BANK_W-1:0],
//   cache invalidated same clock.
// - ROM writes and non-ROM accesses: pure passthrough, no request.
// - rom_ack outside WAIT ignored. cpu_cen_req outside IDLE/HOLD suppressed (never queued).
// - bus_err cleared only by reset.
// STRUCTURE
// - aliens_bus_pkg: state enum (IDLE/REQ/WAIT/HOLD), window decode constants,
//   FIXED_BASE/BANKED_BASE defaults.
// - Sub-module aliens_req_timer: loadable down-counter, start/clear/expired; rest inline.
// TESTING
// - Reset mid-WAIT -> rom_req=0 same clock as rst_n low; bank=0, rd_data=FF after release.
// - Read 0x8123 (cs_rom_n=0), ack after 5 clks with 8'hA5 -> rom_addr=22'h00123,
//   cpu_cen held 0, rd_data=A5, one cpu_cen on next cpu_cen_req; repeat read: no rom_req.
// - Write 0x03 to bank reg, read 0x6010 -> rom_addr=22'h08000+22'h06010=22'h0E010;
//   prior cached entry not reused.
// - Spurious rom_ack in IDLE with 8'h77 -> rd_data, cache, cpu_cen unchanged.
// - TIMEOUT=8, no ack -> rom_req falls after 8 WAIT clocks, bus_err=1, rd_data=FF, CPU released.
// - cs_rom_n=0 and cs_bank_n=0 together at 0xE000 -> fixed mapping 22'h06000 used.

Source files
------------

// File: rtl/aliens_bus_pkg.sv
// Shared definitions for the main-CPU ROM bus responder: FSM states, window
// decode widths and default SDRAM offsets of the fixed and banked ROM windows.
package aliens_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } bus_state_e;

  // Fixed window is the 32 KB at CPU 0x8000-0xFFFF, banked pages are 8 KB.
  localparam int FIXED_OFS_W = 15;
  localparam int BANK_OFS_W  = 13;

  localparam int TMR_W = 16;

  localparam logic [21:0] DEF_FIXED_BASE  = 22'h00000;
  localparam logic [21:0] DEF_BANKED_BASE = 22'h08000;

  // Value the CPU sees when no valid ROM byte is available.
  localparam logic [7:0] RD_EMPTY = 8'hFF;

endpackage

// File: rtl/aliens_req_timer.sv
// Loadable down-counter that flags the last clock of an SDRAM wait window.
// A load value of zero never expires.
module aliens_req_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_load,
  input  logic             i_run,
  input  logic             i_clear,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_load;
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Expires on the clock whose edge would take the count to zero.
  assign o_expired = i_run && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/aliens_rom_bus_responder.sv
// Turns main-CPU reads of the fixed and banked ROM windows into SDRAM read
// requests, stalling the CPU clock enable until the byte returns.
module aliens_rom_bus_responder
  import aliens_bus_pkg::*;
#(
  parameter int                  SDRAM_AW    = 22,
  parameter int                  BANK_W      = 5,
  parameter logic [SDRAM_AW-1:0] FIXED_BASE  = SDRAM_AW'(DEF_FIXED_BASE),
  parameter logic [SDRAM_AW-1:0] BANKED_BASE = SDRAM_AW'(DEF_BANKED_BASE),
  parameter int                  TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_cen_req,
  output logic                cpu_cen,
  input  logic [15:0]         cpu_addr,
  input  logic                cpu_rnw,
  input  logic [7:0]          cpu_dout,
  input  logic                cs_rom_n,
  input  logic                cs_bank_n,
  input  logic                cs_bankreg_n,
  output logic                rom_req,
  output logic [SDRAM_AW-1:0] rom_addr,
  input  logic                rom_ack,
  input  logic [7:0]          rom_data,
  output logic [7:0]          rd_data,
  output logic [BANK_W-1:0]   bank,
  output logic                bus_err
);

  bus_state_e            r_state;
  bus_state_e            w_state_nxt;

  logic                  r_rom_req;
  logic [SDRAM_AW-1:0]   r_rom_addr;
  logic [7:0]            r_rd_data;
  logic [BANK_W-1:0]     r_bank;
  logic                  r_bus_err;
  logic                  r_valid;
  logic [SDRAM_AW-1:0]   r_tag;

  logic [SDRAM_AW-1:0]   w_map_addr;
  logic                  w_rom_rd;
  logic                  w_hit;
  logic                  w_miss_start;
  logic                  w_bank_wr;
  logic                  w_ack;
  logic                  w_expired;
  logic                  w_tmo;
  logic                  w_unused;

  assign w_unused = ^{cpu_addr[15], cpu_dout[7:BANK_W]};

  // cs_rom_n has priority when the PAL asserts both ROM selects.
  always_comb begin
    if (!cs_rom_n) begin
      w_map_addr = FIXED_BASE + SDRAM_AW'(cpu_addr[FIXED_OFS_W-1:0]);
    end else begin
      w_map_addr = BANKED_BASE + SDRAM_AW'({r_bank, cpu_addr[BANK_OFS_W-1:0]});
    end
  end

  assign w_rom_rd     = (!cs_rom_n || !cs_bank_n) && cpu_rnw;
  assign w_hit        = r_valid && (r_tag == w_map_addr);
  assign w_miss_start = (r_state == ST_IDLE) && cpu_cen_req && w_rom_rd && !w_hit;
  assign w_bank_wr    = (r_state == ST_IDLE) && cpu_cen_req && !cs_bankreg_n && !cpu_rnw;
  assign w_ack        = (r_state == ST_WAIT) && rom_ack;
  assign w_tmo        = w_expired && !rom_ack;

  aliens_req_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (r_state == ST_REQ),
    .i_load    (TMR_W'(TIMEOUT)),
    .i_run     (r_state == ST_WAIT),
    .i_clear   (w_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_miss_start) w_state_nxt = ST_REQ;
      ST_REQ:  w_state_nxt = ST_WAIT;
      ST_WAIT: if (rom_ack || w_expired) w_state_nxt = ST_HOLD;
      ST_HOLD: if (cpu_cen_req) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Enable pulses arriving in REQ/WAIT are dropped, not queued.
  always_comb begin
    cpu_cen = 1'b0;
    case (r_state)
      ST_IDLE: cpu_cen = cpu_cen_req && !w_miss_start;
      ST_HOLD: cpu_cen = cpu_cen_req;
      default: cpu_cen = 1'b0;
    endcase
    cpu_cen = cpu_cen && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_req  <= 1'b0;
      r_rom_addr <= '0;
      r_rd_data  <= RD_EMPTY;
      r_bank     <= '0;
      r_bus_err  <= 1'b0;
      r_valid    <= 1'b0;
      r_tag      <= '0;
    end else begin
      if (w_miss_start) r_rom_addr <= w_map_addr;
      if (r_state == ST_REQ) r_rom_req <= 1'b1;
      if (w_ack) begin
        r_rd_data <= rom_data;
        r_tag     <= r_rom_addr;
        r_valid   <= 1'b1;
        r_rom_req <= 1'b0;
      end else if (w_tmo) begin
        r_rd_data <= RD_EMPTY;
        r_bus_err <= 1'b1;
        r_valid   <= 1'b0;
        r_rom_req <= 1'b0;
      end
      if (w_bank_wr) begin
        r_bank  <= cpu_dout[BANK_W-1:0];
        r_valid <= 1'b0;
      end
    end
  end

  assign rom_req  = r_rom_req;
  assign rom_addr = r_rom_addr;
  assign rd_data  = r_rd_data;
  assign bank     = r_bank;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_aliens_rom_bus_responder.sv
// Directed bench for the ROM bus responder: miss/hit flow, banking, spurious
// acks, timeout, dual-select priority and asynchronous reset mid-request.
module tb_aliens_rom_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_cen_req;
  logic        cpu_cen;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_dout;
  logic        cs_rom_n;
  logic        cs_bank_n;
  logic        cs_bankreg_n;
  logic        rom_req;
  logic [21:0] rom_addr;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [7:0]  rd_data;
  logic [4:0]  bank;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  aliens_rom_bus_responder #(
    .SDRAM_AW    (22),
    .BANK_W      (5),
    .FIXED_BASE  (22'h00000),
    .BANKED_BASE (22'h08000),
    .TIMEOUT     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_cen_req  (cpu_cen_req),
    .cpu_cen      (cpu_cen),
    .cpu_addr     (cpu_addr),
    .cpu_rnw      (cpu_rnw),
    .cpu_dout     (cpu_dout),
    .cs_rom_n     (cs_rom_n),
    .cs_bank_n    (cs_bank_n),
    .cs_bankreg_n (cs_bankreg_n),
    .rom_req      (rom_req),
    .rom_addr     (rom_addr),
    .rom_ack      (rom_ack),
    .rom_data     (rom_data),
    .rd_data      (rd_data),
    .bank         (bank),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the cycle a missing read is presented with cpu_cen_req=1:
  // runs REQ, waits waitc extra WAIT clocks, acks with d, then releases the CPU.
  task automatic serve(input logic [21:0] exp_addr, input int waitc,
                       input logic [7:0] d, input string tag);
    tick();
    cpu_cen_req = 1'b0;
    chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    tick();
    chk({tag, "_req"}, 32'(rom_req), 32'd1);
    repeat (waitc) tick();
    rom_ack  = 1'b1;
    rom_data = d;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    chk({tag, "_data"}, 32'(rd_data), 32'(d));
    cpu_cen_req = 1'b1;
    #1 chk({tag, "_rel"}, 32'(cpu_cen), 32'd1);
    tick();
    cpu_cen_req = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    cpu_cen_req  = 1'b1;
    cpu_addr     = 16'h0000;
    cpu_rnw      = 1'b1;
    cpu_dout     = 8'h00;
    cs_rom_n     = 1'b1;
    cs_bank_n    = 1'b1;
    cs_bankreg_n = 1'b1;
    rom_ack      = 1'b0;
    rom_data     = 8'h00;
    #12;
    chk("rst_cen",     32'(cpu_cen),  32'd0);
    chk("rst_req",     32'(rom_req),  32'd0);
    chk("rst_addr",    32'(rom_addr), 32'd0);
    chk("rst_rd",      32'(rd_data),  32'hFF);
    chk("rst_bank",    32'(bank),     32'd0);
    chk("rst_err",     32'(bus_err),  32'd0);
    cpu_cen_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Fixed-window miss, ack in the fifth WAIT clock
    cpu_addr = 16'h8123; cs_rom_n = 1'b0; cpu_cen_req = 1'b1;
    #1 chk("miss_cen", 32'(cpu_cen), 32'd0);
    tick();
    cpu_cen_req = 1'b0;
    chk("miss_addr", 32'(rom_addr), 32'h00123);
    chk("req_lag",   32'(rom_req),  32'd0);
    tick();
    chk("wait_req",  32'(rom_req),  32'd1);
    cpu_cen_req = 1'b1;
    #1 chk("wait_cen", 32'(cpu_cen), 32'd0);
    tick();
    cpu_cen_req = 1'b0;
    repeat (3) tick();
    chk("wait_hold", 32'(rom_req),  32'd1);
    chk("wait_addr", 32'(rom_addr), 32'h00123);
    rom_ack = 1'b1; rom_data = 8'hA5;
    tick();
    rom_ack = 1'b0; rom_data = 8'h00;
    chk("ack_rd",    32'(rd_data),  32'hA5);
    chk("ack_req",   32'(rom_req),  32'd0);
    chk("hold_cen",  32'(cpu_cen),  32'd0);
    tick();
    chk("hold_cen2", 32'(cpu_cen),  32'd0);
    cpu_cen_req = 1'b1;
    #1 chk("rel_cen", 32'(cpu_cen), 32'd1);
    tick();
    #1 chk("hit_cen", 32'(cpu_cen), 32'd1);
    tick();
    cpu_cen_req = 1'b0;
    chk("hit_noreq", 32'(rom_req), 32'd0);
    tick();
    chk("hit_noreq2", 32'(rom_req), 32'd0);

    // Spurious ack while IDLE on a non-ROM access
    cs_rom_n = 1'b1; cpu_cen_req = 1'b1; rom_ack = 1'b1; rom_data = 8'h77;
    #1 chk("spur_cen", 32'(cpu_cen), 32'd1);
    tick();
    rom_ack = 1'b0; rom_data = 8'h00; cpu_cen_req = 1'b0;
    chk("spur_rd", 32'(rd_data), 32'hA5);
    cs_rom_n = 1'b0; cpu_cen_req = 1'b1;
    #1 chk("spur_hit", 32'(cpu_cen), 32'd1);
    tick();
    cpu_cen_req = 1'b0;
    tick();
    chk("spur_noreq", 32'(rom_req), 32'd0);

    // Bank register write (upper data bits ignored), then banked read
    cs_rom_n = 1'b1; cs_bankreg_n = 1'b0; cpu_rnw = 1'b0; cpu_dout = 8'hE3; cpu_cen_req = 1'b1;
    #1 chk("bw_cen", 32'(cpu_cen), 32'd1);
    tick();
    cpu_cen_req = 1'b0; cs_bankreg_n = 1'b1; cpu_rnw = 1'b1;
    chk("bw_bank", 32'(bank), 32'd3);
    cpu_addr = 16'h6010; cs_bank_n = 1'b0; cpu_cen_req = 1'b1;
    #1 chk("bank_miss", 32'(cpu_cen), 32'd0);
    serve(22'h0E010, 1, 8'h5A, "bank");
    cpu_cen_req = 1'b1;
    #1 chk("bank_hit", 32'(cpu_cen), 32'd1);
    tick();
    cpu_cen_req = 1'b0;

    // Rewriting the same bank still invalidates the cached byte
    cs_bank_n = 1'b1; cs_bankreg_n = 1'b0; cpu_rnw = 1'b0; cpu_dout = 8'h03; cpu_cen_req = 1'b1;
    tick();
    cs_bankreg_n = 1'b1; cpu_rnw = 1'b1; cs_bank_n = 1'b0;
    #1 chk("inval_miss", 32'(cpu_cen), 32'd0);
    serve(22'h0E010, 0, 8'hC3, "inval");

    // Both ROM selects low: fixed mapping wins
    cs_rom_n = 1'b0; cs_bank_n = 1'b0; cpu_addr = 16'hE000; cpu_cen_req = 1'b1;
    #1 chk("both_miss", 32'(cpu_cen), 32'd0);
    serve(22'h06000, 2, 8'h11, "both");
    cs_bank_n = 1'b1;

    // Timeout after 8 WAIT clocks with no ack
    cpu_addr = 16'h9000; cpu_cen_req = 1'b1;
    tick();
    cpu_cen_req = 1'b0;
    chk("tmo_addr", 32'(rom_addr), 32'h01000);
    tick();
    chk("tmo_req1", 32'(rom_req), 32'd1);
    repeat (7) tick();
    chk("tmo_req8", 32'(rom_req), 32'd1);
    chk("tmo_err0", 32'(bus_err), 32'd0);
    tick();
    chk("tmo_req",  32'(rom_req), 32'd0);
    chk("tmo_err",  32'(bus_err), 32'd1);
    chk("tmo_rd",   32'(rd_data), 32'hFF);
    cpu_cen_req = 1'b1;
    #1 chk("tmo_rel", 32'(cpu_cen), 32'd1);
    tick();
    #1 chk("tmo_nocache", 32'(cpu_cen), 32'd0);
    serve(22'h01000, 0, 8'h3C, "retry");
    chk("err_sticky", 32'(bus_err), 32'd1);

    // Asynchronous reset in the middle of WAIT
    cpu_addr = 16'hA000; cpu_cen_req = 1'b1;
    tick();
    cpu_cen_req = 1'b0;
    tick();
    chk("rw_req", 32'(rom_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rw_req_drop", 32'(rom_req), 32'd0);
    chk("rw_err_clr", 32'(bus_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rw_bank", 32'(bank),    32'd0);
    chk("rw_rd",   32'(rd_data), 32'hFF);
    chk("rw_req2", 32'(rom_req), 32'd0);
    cs_rom_n = 1'b1; cpu_cen_req = 1'b1;
    #1 chk("rw_idle_cen", 32'(cpu_cen), 32'd1);
    tick();
    cpu_cen_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
